// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and bit counting.
// Functions work on a wide word; callers zero-extend narrower pointers into it.
package fifo_cdc_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int PTR_W         = ADDR_SIZE_DEF + 1;
    localparam int MAX_W         = 64;

    typedef logic [MAX_W-1:0] word_t;

    // Status snapshot of one pointer synchronizer.
    typedef struct packed {
        logic valid;
        logic changed;
        logic err;
    } sync_status_t;

    // Zero-extended upper bits stay zero, so the full-width prefix XOR is width-generic.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input word_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic WIDTH x STAGES synchronizer flop chain with synchronous reset.
// Each bit must only ever change one at a time at the source (Gray code or single-bit control).
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] q_reg;

            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray-coded FIFO pointer synchronizer for the destination domain: sync chain,
// registered binary conversion, change pulse, warm-up qualification and integrity monitor.
module gray_ptr_sync
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE:0]   gray_in,
    input  logic                 err_clr,
    output logic [ADDR_SIZE:0]   sync_gray,
    output logic [ADDR_SIZE:0]   sync_bin,
    output logic                 sync_valid,
    output logic                 ptr_changed,
    output logic                 gray_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int W        = ADDR_SIZE + 1;
    localparam int WARM_MAX = STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_MAX + 1);

    localparam logic [WARM_W-1:0]    WARM_END = WARM_W'(WARM_MAX);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be in 2..4");
        end
        if (W >= MAX_W) begin : g_bad_width
            $error("gray_ptr_sync: ADDR_SIZE too large for package word");
        end
    endgenerate

    logic [W-1:0]         sync_gray_d_reg, sync_gray_d_next;
    logic [W-1:0]         sync_bin_reg, sync_bin_next;
    logic                 ptr_changed_reg, ptr_changed_next;
    logic                 gray_err_reg, gray_err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic [WARM_W-1:0]    warm_cnt_reg, warm_cnt_next;

    logic [W-1:0] sync_gray_w;
    word_t        bin_full;
    word_t        diff_full;
    logic         step_bad;
    logic         unused_bin_hi;
    sync_status_t status;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (sync_gray_w)
    );

    assign status.valid   = (warm_cnt_reg == WARM_END);
    assign status.changed = ptr_changed_reg;
    assign status.err     = gray_err_reg;

    // Converter output is wide; only the pointer bits are meaningful.
    assign unused_bin_hi = ^bin_full[MAX_W-1:W];

    always_comb begin
        sync_gray_d_next = sync_gray_w;
        bin_full         = gray2bin(MAX_W'(sync_gray_w));
        sync_bin_next    = bin_full[W-1:0];
        diff_full        = MAX_W'(sync_gray_w ^ sync_gray_d_reg);

        // Checks stay disabled until the chain has flushed whatever was in flight at reset.
        step_bad         = status.valid && (popcount(diff_full) > 1);
        ptr_changed_next = status.valid && (sync_gray_w != sync_gray_d_reg);

        if (warm_cnt_reg == WARM_END) begin
            warm_cnt_next = warm_cnt_reg;
        end else begin
            warm_cnt_next = warm_cnt_reg + WARM_W'(1);
        end

        gray_err_next = gray_err_reg;
        err_cnt_next  = err_cnt_reg;
        if (step_bad) begin
            // A fresh error in the clearing cycle restarts the count at one.
            gray_err_next = 1'b1;
            if (err_clr) begin
                err_cnt_next = ERR_CNT_W'(1);
            end else if (err_cnt_reg != CNT_MAX) begin
                err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            gray_err_next = 1'b0;
            err_cnt_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_gray_d_reg <= '0;
            sync_bin_reg    <= '0;
            ptr_changed_reg <= 1'b0;
            gray_err_reg    <= 1'b0;
            err_cnt_reg     <= '0;
            warm_cnt_reg    <= '0;
        end else begin
            sync_gray_d_reg <= sync_gray_d_next;
            sync_bin_reg    <= sync_bin_next;
            ptr_changed_reg <= ptr_changed_next;
            gray_err_reg    <= gray_err_next;
            err_cnt_reg     <= err_cnt_next;
            warm_cnt_reg    <= warm_cnt_next;
        end
    end

    assign sync_gray   = sync_gray_w;
    assign sync_bin    = sync_bin_reg;
    assign sync_valid  = status.valid;
    assign ptr_changed = status.changed;
    assign gray_err    = status.err;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: default instance, a 2-bit error counter instance and a
// three-stage instance, all driven from the same stimulus.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [4:0] gray_in = '0;

    logic [4:0] a_sync_gray, a_sync_bin;
    logic       a_sync_valid, a_ptr_changed, a_gray_err;
    logic [7:0] a_err_cnt;

    logic [4:0] b_sync_gray, b_sync_bin;
    logic       b_sync_valid, b_ptr_changed, b_gray_err;
    logic [1:0] b_err_cnt;

    logic [4:0] c_sync_gray, c_sync_bin;
    logic       c_sync_valid, c_ptr_changed, c_gray_err;
    logic [7:0] c_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    gray_ptr_sync #(.ADDR_SIZE(4), .STAGES(2), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .sync_gray(a_sync_gray), .sync_bin(a_sync_bin), .sync_valid(a_sync_valid),
        .ptr_changed(a_ptr_changed), .gray_err(a_gray_err), .err_cnt(a_err_cnt)
    );

    gray_ptr_sync #(.ADDR_SIZE(4), .STAGES(2), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .sync_gray(b_sync_gray), .sync_bin(b_sync_bin), .sync_valid(b_sync_valid),
        .ptr_changed(b_ptr_changed), .gray_err(b_gray_err), .err_cnt(b_err_cnt)
    );

    gray_ptr_sync #(.ADDR_SIZE(4), .STAGES(3), .ERR_CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .sync_gray(c_sync_gray), .sync_bin(c_sync_bin), .sync_valid(c_sync_valid),
        .ptr_changed(c_ptr_changed), .gray_err(c_gray_err), .err_cnt(c_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0; gray_in = 5'b10101;
        tick();
        n_tests++;
        if ({a_sync_gray, a_sync_bin} !== 10'b0) begin
            n_fail++; $display("FAIL reset_ptrs: got %b/%b want 00000/00000", a_sync_gray, a_sync_bin);
        end
        n_tests++;
        if ({a_sync_valid, a_ptr_changed, a_gray_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {a_sync_valid, a_ptr_changed, a_gray_err});
        end
        n_tests++;
        if (a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", a_err_cnt);
        end
        $display("[TB] reset applied");
    endtask

    task automatic test_latency();
        gray_in = 5'b00000; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        n_tests++;
        if (a_sync_valid !== 1'b0) begin
            n_fail++; $display("FAIL warmup_edge2: sync_valid got %b want 0", a_sync_valid);
        end
        tick();
        n_tests++;
        if (a_sync_valid !== 1'b1) begin
            n_fail++; $display("FAIL warmup_edge3: sync_valid got %b want 1", a_sync_valid);
        end
        gray_in = 5'b00001;
        tick();
        n_tests++;
        if (a_sync_gray !== 5'b00000) begin
            n_fail++; $display("FAIL lat_edge1: sync_gray got %b want 00000", a_sync_gray);
        end
        tick();
        n_tests++;
        if (a_sync_gray !== 5'b00001 || a_ptr_changed !== 1'b0) begin
            n_fail++; $display("FAIL lat_edge2: sync_gray/ptr_changed got %b/%b want 00001/0", a_sync_gray, a_ptr_changed);
        end
        tick();
        n_tests++;
        if (a_sync_bin !== 5'b00001 || a_ptr_changed !== 1'b1) begin
            n_fail++; $display("FAIL lat_edge3: sync_bin/ptr_changed got %b/%b want 00001/1", a_sync_bin, a_ptr_changed);
        end
        tick();
        n_tests++;
        if (a_ptr_changed !== 1'b0) begin
            n_fail++; $display("FAIL lat_edge4: ptr_changed got %b want 0", a_ptr_changed);
        end
        $display("[TB] latency step 00000->00001 done");
    endtask

    task automatic test_walk();
        int pulses;
        int e;
        int v;
        gray_in = 5'b00000;
        repeat (5) tick();
        pulses = 0;
        exp_q.delete();
        for (int t = 0; t < 32 * 3 + 4; t++) begin
            if (t % 3 == 0 && t / 3 < 32) begin
                v = (t / 3 + 1) % 32;
                gray_in = b2g(5'(v));
                exp_q.push_back(v);
            end
            tick();
            if (a_ptr_changed === 1'b1) begin
                pulses++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL walk_extra_pulse: got pulse with sync_bin %b want none", a_sync_bin);
                end else begin
                    e = exp_q.pop_front();
                    if (a_sync_bin !== 5'(e)) begin
                        n_fail++; $display("FAIL walk_bin: got %b want %b", a_sync_bin, 5'(e));
                    end else begin
                        $display("[TB] walk pulse %0d sync_bin=%b", pulses, a_sync_bin);
                    end
                end
            end
        end
        n_tests++;
        if (pulses != 32 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL walk_pulse_count: got %0d pulses (%0d pending) want 32 (0)", pulses, exp_q.size());
        end
        n_tests++;
        if (a_gray_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL walk_no_err: gray_err/err_cnt got %b/%0d want 0/0", a_gray_err, a_err_cnt);
        end
    endtask

    task automatic test_warmup_hold();
        gray_in = 5'b01101; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (a_sync_valid !== (k >= 3) || a_ptr_changed !== 1'b0) begin
                n_fail++; $display("FAIL hold_edge%0d: valid/ptr_changed got %b/%b want %b/0", k, a_sync_valid, a_ptr_changed, (k >= 3));
            end
        end
        n_tests++;
        if (a_sync_bin !== 5'b01001) begin
            n_fail++; $display("FAIL hold_bin: got %b want 01001", a_sync_bin);
        end
        n_tests++;
        if (a_gray_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL hold_no_err: gray_err/err_cnt got %b/%0d want 0/0", a_gray_err, a_err_cnt);
        end
        $display("[TB] nonzero pointer held through reset done");
    endtask

    task automatic test_illegal_step();
        gray_in = 5'b00000; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        gray_in = 5'b00011;
        tick(); tick();
        n_tests++;
        if (a_sync_gray !== 5'b00011 || a_gray_err !== 1'b0) begin
            n_fail++; $display("FAIL illegal_pre: sync_gray/gray_err got %b/%b want 00011/0", a_sync_gray, a_gray_err);
        end
        tick();
        n_tests++;
        if (a_gray_err !== 1'b1 || a_err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL illegal_flag: gray_err/err_cnt got %b/%0d want 1/1", a_gray_err, a_err_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (a_gray_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL err_clr: gray_err/err_cnt got %b/%0d want 0/0", a_gray_err, a_err_cnt);
        end
        tick();
        n_tests++;
        if (a_gray_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL err_clr_hold: gray_err/err_cnt got %b/%0d want 0/0", a_gray_err, a_err_cnt);
        end
        $display("[TB] illegal step 00000->00011 and clear done");
    endtask

    task automatic test_saturation();
        int e;
        exp_q.delete();
        for (int k = 1; k <= 5; k++) begin
            gray_in = (k % 2 == 1) ? 5'b00000 : 5'b00011;
            exp_q.push_back((k > 3) ? 3 : k);
            repeat (3) begin
                tick();
                if (b_ptr_changed === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL sat_extra_pulse: got err_cnt %0d want no pulse", b_err_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (b_err_cnt !== 2'(e) || b_gray_err !== 1'b1) begin
                            n_fail++; $display("FAIL sat_cnt: gray_err/err_cnt got %b/%0d want 1/%0d", b_gray_err, b_err_cnt, e);
                        end else begin
                            $display("[TB] illegal step %0d err_cnt=%0d", k, b_err_cnt);
                        end
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || a_err_cnt !== 8'd5) begin
            n_fail++; $display("FAIL sat_totals: pending %0d, wide err_cnt %0d want 0, 5", exp_q.size(), a_err_cnt);
        end
        gray_in = 5'b00011;
        tick(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (b_gray_err !== 1'b1 || b_err_cnt !== 2'd1) begin
            n_fail++; $display("FAIL clr_vs_err_narrow: gray_err/err_cnt got %b/%0d want 1/1", b_gray_err, b_err_cnt);
        end
        n_tests++;
        if (a_gray_err !== 1'b1 || a_err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL clr_vs_err_wide: gray_err/err_cnt got %b/%0d want 1/1", a_gray_err, a_err_cnt);
        end
    endtask

    task automatic test_midstream_reset();
        gray_in = b2g(5'b10110);
        repeat (4) tick();
        n_tests++;
        if (a_sync_bin !== 5'b10110) begin
            n_fail++; $display("FAIL mid_pre_bin: got %b want 10110", a_sync_bin);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({a_sync_gray, a_sync_bin, a_sync_valid, a_ptr_changed, a_gray_err} !== 13'b0 || a_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_rst_a: gray/bin/valid/pc/err/cnt got %b/%b/%b/%b/%b/%0d want all 0",
                               a_sync_gray, a_sync_bin, a_sync_valid, a_ptr_changed, a_gray_err, a_err_cnt);
        end
        n_tests++;
        if (c_sync_gray !== 5'b0 || c_sync_valid !== 1'b0 || c_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_rst_c: gray/valid/cnt got %b/%b/%0d want 00000/0/0", c_sync_gray, c_sync_valid, c_err_cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (a_sync_valid !== (k >= 3) || c_sync_valid !== (k >= 4)) begin
                n_fail++; $display("FAIL mid_warmup_edge%0d: valid a/c got %b/%b want %b/%b", k, a_sync_valid, c_sync_valid, (k >= 3), (k >= 4));
            end
            if (k == 2) begin
                n_tests++;
                if (a_sync_gray !== 5'b11101 || c_sync_gray !== 5'b00000) begin
                    n_fail++; $display("FAIL mid_lat_edge2: sync_gray a/c got %b/%b want 11101/00000", a_sync_gray, c_sync_gray);
                end
            end
            if (k == 3) begin
                n_tests++;
                if (c_sync_gray !== 5'b11101) begin
                    n_fail++; $display("FAIL mid_lat3_edge3: sync_gray got %b want 11101", c_sync_gray);
                end
            end
            n_tests++;
            if (a_ptr_changed !== 1'b0 || c_ptr_changed !== 1'b0 || c_gray_err !== 1'b0) begin
                n_fail++; $display("FAIL mid_quiet_edge%0d: pc a/c, err c got %b/%b/%b want 0/0/0", k, a_ptr_changed, c_ptr_changed, c_gray_err);
            end
        end
        n_tests++;
        if (c_sync_bin !== 5'b10110) begin
            n_fail++; $display("FAIL mid_bin_c: got %b want 10110", c_sync_bin);
        end
        $display("[TB] mid-stream reset done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_walk();
        test_warmup_hold();
        test_illegal_step();
        test_saturation();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
